// File: rtl/led_pulser.sv
// Stretches single-cycle event strobes into LED pulses with a fixed on-time and off-gap,
// queueing events that arrive mid-pulse. Define LED_PWM_EN to dim the on-phase with a DUTY/16 PWM.
module led_pulser #(
   parameter int unsigned DELAY  = 16,
   parameter int unsigned PEND_W = 4,
   parameter int unsigned DUTY   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EV,
   output logic              LED,
   output logic              BUSY,
   output logic [PEND_W-1:0] PEND,
   output logic              OVF
);

   localparam logic [DELAY-1:0]  TMR_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   if (DUTY > 16) begin : g_duty_range
      $error("led_pulser: DUTY must lie in 0..16");
   end

   state_t            state_q, state_d;
   logic [DELAY-1:0]  timer_q, timer_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              led_q, led_d;
   logic              busy_q, busy_d;
   logic              start;
   logic              tmr_done;
   logic              have_work;

`ifdef LED_PWM_EN
   logic [3:0] pwm_q, pwm_d;
`endif

   // Phase sequencing: every state entry clears the timer
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      start     = 1'b0;
      tmr_done  = (timer_q == TMR_MAX);
      have_work = EV || (pend_q != '0);
      case (state_q)
         IDLE: begin
            if (have_work) begin
               state_d = ON;
               timer_d = '0;
               start   = 1'b1;
            end
         end
         ON: begin
            if (tmr_done) begin
               state_d = GAP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + DELAY'(1);
            end
         end
         GAP: begin
            if (tmr_done) begin
               timer_d = '0;
               if (have_work) begin
                  state_d = ON;
                  start   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q + DELAY'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // A pulse start consumes one event: from the queue if non-empty, else the live strobe
   always_comb begin
      pend_d = pend_q;
      ovf_d  = 1'b0;
      if (start && (pend_q != '0)) begin
         if (!EV) begin
            pend_d = pend_q - PEND_W'(1);
         end
      end else if (!start && EV) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_W'(1);
         end
      end
   end

   // LED and BUSY are registered from the next state so they never glitch
   always_comb begin
      busy_d = (state_d != IDLE);
`ifdef LED_PWM_EN
      pwm_d  = pwm_q + 4'd1;
      led_d  = (state_d == ON) && ({1'b0, pwm_d} < 5'(DUTY));
`else
      led_d  = (state_d == ON);
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
      end
   end

`ifdef LED_PWM_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pwm_q <= 4'd0;
      end else begin
         pwm_q <= pwm_d;
      end
   end
`endif

   assign LED  = led_q;
   assign BUSY = busy_q;
   assign PEND = pend_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_led_pulser.sv
// Directed bench for led_pulser with DELAY=3 (8-cycle phases) and PEND_W=2 (queue depth 3).
module tb_led_pulser;

   localparam int unsigned DELAY  = 3;
   localparam int unsigned PEND_W = 2;

   logic              CLK;
   logic              RST;
   logic              EV;
   logic              LED;
   logic              BUSY;
   logic [PEND_W-1:0] PEND;
   logic              OVF;

   int errors;
   int checks;

   led_pulser #(
      .DELAY  (DELAY),
      .PEND_W (PEND_W),
      .DUTY   (8)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .EV   (EV),
      .LED  (LED),
      .BUSY (BUSY),
      .PEND (PEND),
      .OVF  (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      EV  = 1'b0;
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      EV  = 1'b0;
      RST = 1'b1;
      repeat (3) tick();
      checks++;
      if (LED !== 1'b0 || BUSY !== 1'b0 || PEND !== 2'd0 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got led=%b busy=%b pend=%0d ovf=%b required 0 0 0 0",
                  LED, BUSY, PEND, OVF);
      end
      RST = 1'b0;
      tick();
      // events at relative cycles 0, 2, 4 leave two queued while ON
      EV = 1'b1; tick();
      EV = 1'b0; tick();
      EV = 1'b1; tick();
      EV = 1'b0; tick();
      EV = 1'b1; tick();
      EV = 1'b0;
      checks++;
      if (LED !== 1'b1 || PEND !== 2'd2) begin
         errors++;
         $display("FAIL reset_setup: got led=%b pend=%0d required led=1 pend=2", LED, PEND);
      end
      #2 RST = 1'b1;
      #1;
      checks++;
      if (LED !== 1'b0 || BUSY !== 1'b0 || PEND !== 2'd0) begin
         errors++;
         $display("FAIL reset_async: got led=%b busy=%b pend=%0d required 0 0 0", LED, BUSY, PEND);
      end
      tick();
      RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (LED !== 1'b0 || BUSY !== 1'b0 || PEND !== 2'd0) begin
            errors++;
            $display("FAIL reset_stays_idle[%0d]: got led=%b busy=%b pend=%0d required 0 0 0",
                     i, LED, BUSY, PEND);
         end
      end
   endtask

   task automatic test_single();
      logic exp_led;
      logic exp_busy;
      do_reset();
      for (int i = 0; i <= 18; i++) begin
         EV       = (i == 0);
         exp_led  = (i >= 1) && (i <= 8);
         exp_busy = (i >= 1) && (i <= 16);
         checks++;
         if (LED !== exp_led || BUSY !== exp_busy || PEND !== 2'd0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL single[%0d]: got led=%b busy=%b pend=%0d ovf=%b required %b %b 0 0",
                     i, LED, BUSY, PEND, OVF, exp_led, exp_busy);
         end
         tick();
      end
      EV = 1'b0;
   endtask

   task automatic test_queued();
      logic exp_led;
      logic exp_busy;
      do_reset();
      for (int i = 0; i <= 52; i++) begin
         EV       = (i == 0) || (i == 2) || (i == 4);
         exp_busy = (i >= 1) && (i <= 48);
         exp_led  = exp_busy && (((i - 1) % 16) < 8);
         checks++;
         if (LED !== exp_led || BUSY !== exp_busy) begin
            errors++;
            $display("FAIL queued_led[%0d]: got led=%b busy=%b required %b %b",
                     i, LED, BUSY, exp_led, exp_busy);
         end
         if (i == 3 || i == 5 || i == 16 || i == 18 || i == 32 || i == 34) begin
            checks++;
            if (PEND !== ((i == 3 || i == 18 || i == 32) ? 2'd1 : (i == 34) ? 2'd0 : 2'd2)) begin
               errors++;
               $display("FAIL queued_pend[%0d]: got %0d required %0d", i, PEND,
                        (i == 3 || i == 18 || i == 32) ? 1 : (i == 34) ? 0 : 2);
            end
         end
         tick();
      end
      EV = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i <= 34; i++) begin
         EV = (i == 0) || (i == 2) || (i == 16);
         if (i == 16) begin
            checks++;
            if (LED !== 1'b0 || BUSY !== 1'b1 || PEND !== 2'd1) begin
               errors++;
               $display("FAIL simul_gap_end: got led=%b busy=%b pend=%0d required 0 1 1",
                        LED, BUSY, PEND);
            end
         end
         if (i == 17 || i == 18) begin
            checks++;
            if (LED !== 1'b1 || PEND !== 2'd1) begin
               errors++;
               $display("FAIL simul_restart[%0d]: got led=%b pend=%0d required 1 1", i, LED, PEND);
            end
         end
         if (i == 34) begin
            checks++;
            if (LED !== 1'b1 || PEND !== 2'd0) begin
               errors++;
               $display("FAIL simul_third: got led=%b pend=%0d required 1 0", LED, PEND);
            end
         end
         tick();
      end
      EV = 1'b0;
   endtask

   task automatic test_overflow();
      int   rises;
      logic prev_led;
      rises    = 0;
      prev_led = 1'b0;
      do_reset();
      for (int i = 0; i <= 80; i++) begin
         EV = (i <= 4);
         checks++;
         if (OVF !== (i == 5)) begin
            errors++;
            $display("FAIL ovf_pulse[%0d]: got %b required %b", i, OVF, (i == 5));
         end
         if (i == 4 || i == 5 || i == 6) begin
            checks++;
            if (PEND !== 2'd3) begin
               errors++;
               $display("FAIL ovf_pend[%0d]: got %0d required 3", i, PEND);
            end
         end
         if (LED === 1'b1 && prev_led === 1'b0) rises++;
         prev_led = LED;
         tick();
      end
      EV = 1'b0;
      checks++;
      if (rises != 4) begin
         errors++;
         $display("FAIL ovf_pulse_count: got %0d required 4", rises);
      end
      checks++;
      if (BUSY !== 1'b0 || PEND !== 2'd0) begin
         errors++;
         $display("FAIL ovf_drained: got busy=%b pend=%0d required 0 0", BUSY, PEND);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      RST    = 1'b1;
      EV     = 1'b0;
      test_reset();
      test_single();
      test_queued();
      test_simultaneous();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
